// File: rtl/ahb_imem_if.sv
// AHB-lite bus bundle between the I-cache line-fill master and the instruction memory slave.
interface ahb_imem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_imem_slave.sv
// AHB-lite instruction memory slave: SINGLE/INCR/WRAP4/INCR4 reads with wait states and ERROR checks.
// Optional AHB_IMEM_WRITE_EN accepts legal word writes; otherwise any write gets an ERROR response.
module ahb_imem_slave #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NSEQ_WAIT = 2,
    parameter int unsigned SEQ_WAIT  = 0
) (
    input  logic                         hclk,
    input  logic                         hrstn,
    ahb_imem_if.slave                    bus,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [31:0]                  ld_data
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'd0;
    localparam logic [2:0] BU_WRAP4  = 3'd2;
    localparam logic [2:0] BU_INCR4  = 3'd3;

    localparam logic [3:0] NSEQ_W = 4'(NSEQ_WAIT);
    localparam logic [3:0] SEQ_W  = 4'(SEQ_WAIT);

    function automatic logic [31:0] next_addr(input logic [31:0] prev, input logic [2:0] burst);
        if (burst == BU_WRAP4)
            next_addr = {prev[31:4], prev[3:2] + 2'd1, 2'b00};
        else
            next_addr = prev + 32'd4;
    endfunction

    logic [2:0]    state_p1;
    logic [3:0]    wcnt_p1;
    logic [AW-1:0] idx_p1;
    logic [31:0]   hrdata_p1;
    logic          trk_act_p1;
    logic [2:0]    trk_burst_p1;
    logic [2:0]    trk_beats_p1;
    logic [31:0]   trk_addr_p1;
    logic [31:0]   mem [MEM_WORDS];

    logic          ready;
    logic          accept;
    logic          is_seq;
    logic          in_range;
    logic          fixed4;
    logic          burst_full;
    logic          seq_bad;
    logic          wr_bad;
    logic          legal;
    logic [31:0]   off;
    logic [3:0]    wait_n;
    logic [AW-1:0] idx;

    assign ready  = (state_p1 != ST_WAIT) && (state_p1 != ST_ERR1);
    assign accept = bus.hsel & bus.hready & bus.htrans[1] & ready;
    assign is_seq = (bus.htrans == TR_SEQ);

    assign off      = bus.haddr - BASE_ADDR;
    assign in_range = (bus.haddr >= BASE_ADDR) && ({1'b0, off} < (33'(MEM_WORDS) << 2));
    assign idx      = off[AW+1:2];

    // A fixed-length burst is exhausted after its fourth beat; SINGLE has no follow-on beats.
    assign fixed4     = (trk_burst_p1 == BU_WRAP4) || (trk_burst_p1 == BU_INCR4);
    assign burst_full = (trk_burst_p1 == BU_SINGLE) || (fixed4 && (trk_beats_p1 == 3'd4));
    assign seq_bad    = is_seq & (~trk_act_p1 | burst_full |
                                  (bus.haddr != next_addr(trk_addr_p1, trk_burst_p1)));

`ifdef AHB_IMEM_WRITE_EN
    logic wr_p1;
    assign wr_bad = 1'b0;
`else
    logic unused_wdata;
    assign wr_bad       = bus.hwrite;
    assign unused_wdata = ^bus.hwdata;
`endif

    assign legal  = (bus.hsize == 3'b010) && (bus.haddr[1:0] == 2'b00) && in_range &&
                    !wr_bad && !seq_bad;
    assign wait_n = is_seq ? SEQ_W : NSEQ_W;

    // Address phase -> data phase boundary
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_p1     <= ST_IDLE;
            wcnt_p1      <= 4'd0;
            idx_p1       <= '0;
            hrdata_p1    <= 32'd0;
            trk_act_p1   <= 1'b0;
            trk_burst_p1 <= BU_SINGLE;
            trk_beats_p1 <= 3'd0;
            trk_addr_p1  <= 32'd0;
`ifdef AHB_IMEM_WRITE_EN
            wr_p1        <= 1'b0;
`endif
        end else begin
            case (state_p1)
                ST_WAIT: begin
                    if (wcnt_p1 == 4'd1) begin
                        state_p1  <= ST_DATA;
                        wcnt_p1   <= 4'd0;
                        hrdata_p1 <= mem[idx_p1];
                    end else begin
                        wcnt_p1 <= wcnt_p1 - 4'd1;
                    end
                end
                ST_ERR1: state_p1 <= ST_ERR2;
                default: begin
                    if (accept) begin
                        idx_p1 <= idx;
`ifdef AHB_IMEM_WRITE_EN
                        wr_p1  <= bus.hwrite;
`endif
                        if (!legal) begin
                            state_p1     <= ST_ERR1;
                            trk_act_p1   <= 1'b0;
                            trk_beats_p1 <= 3'd0;
                        end else begin
                            trk_act_p1  <= 1'b1;
                            trk_addr_p1 <= bus.haddr;
                            if (is_seq) begin
                                if (trk_beats_p1 != 3'd7)
                                    trk_beats_p1 <= trk_beats_p1 + 3'd1;
                            end else begin
                                trk_burst_p1 <= bus.hburst;
                                trk_beats_p1 <= 3'd1;
                            end
                            if (wait_n == 4'd0) begin
                                state_p1  <= ST_DATA;
                                hrdata_p1 <= mem[idx];
                            end else begin
                                state_p1 <= ST_WAIT;
                                wcnt_p1  <= wait_n;
                            end
                        end
                    end else begin
                        state_p1 <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Storage: a bus write issued later in program order wins over a coincident preload.
    always_ff @(posedge hclk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
`ifdef AHB_IMEM_WRITE_EN
        if ((state_p1 == ST_DATA) && wr_p1)
            mem[idx_p1] <= bus.hwdata;
`endif
    end

    assign bus.hrdata    = hrdata_p1;
    assign bus.hreadyout = ready;
    assign bus.hresp     = (state_p1 == ST_ERR1) || (state_p1 == ST_ERR2);
endmodule

// File: tb/tb_ahb_imem_slave.sv
// Scoreboard bench for ahb_imem_slave: directed line-fill scenarios, then randomized bursts.
module tb_ahb_imem_slave;
    localparam int          MW   = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          NW   = 2;
    localparam int          SW   = 0;

    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3;

    logic        hclk = 1'b0;
    logic        hrstn = 1'b0;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    ahb_imem_if ifc();
    assign ifc.hready = ifc.hreadyout;

    ahb_imem_slave #(
        .MEM_WORDS(MW), .BASE_ADDR(BASE), .NSEQ_WAIT(NW), .SEQ_WAIT(SW)
    ) dut (
        .hclk(hclk), .hrstn(hrstn), .bus(ifc.slave),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          waits;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          pending = 0;
    int          lo_ok = 0;
    int          lo_err = 0;
    logic [31:0] mmem [MW];
    bit          m_act = 0;
    logic [2:0]  m_burst = 3'd0;
    int          m_beats = 0;
    logic [31:0] m_last = 32'd0;

    // Reference model: decides the response of an accepted NONSEQ/SEQ from the protocol rules.
    function automatic void model_accept(input logic [1:0] tr, input logic [31:0] a, input logic w,
                                         input logic [2:0] b, input logic [2:0] sz,
                                         input logic [31:0] wd);
        exp_t        e;
        longint      off;
        bit          ok;
        int          wi;
        logic [31:0] want;
        off = longint'(a) - longint'(BASE);
        ok  = (sz == 3'b010) && ((a & 32'd3) == 0) && (off >= 0) && (off < 4 * MW);
`ifndef AHB_IMEM_WRITE_EN
        if (w) ok = 0;
`endif
        if (tr == T_SEQ) begin
            if (!m_act || m_burst == B_SINGLE ||
                ((m_burst == B_WRAP4 || m_burst == B_INCR4) && m_beats >= 4)) begin
                ok = 0;
            end else begin
                if (m_burst == B_WRAP4) want = (m_last & ~32'hF) | ((m_last + 32'd4) & 32'hC);
                else                    want = m_last + 32'd4;
                if (a != want) ok = 0;
            end
        end
        e.addr  = a;
        e.err   = !ok;
        e.chk   = 0;
        e.data  = 32'd0;
        e.waits = (tr == T_SEQ) ? SW : NW;
        if (!ok) begin
            m_act = 0;
        end else begin
            if (tr == T_NSEQ) begin
                m_act = 1; m_burst = b; m_beats = 1;
            end else begin
                m_beats++;
            end
            m_last = a;
            wi = int'(off >>> 2);
            if (w) mmem[wi] = wd;
            else begin e.chk = 1; e.data = mmem[wi]; end
        end
        sb.push_back(e);
    endfunction

    // Monitor: evaluated mid-cycle, describing what the upcoming rising edge will see.
    always @(negedge hclk) begin
        exp_t e;
        bit   ok;
        if (hrstn) begin
            if (pending) begin
                if (!ifc.hreadyout) begin
                    if (ifc.hresp) lo_err++;
                    else           lo_ok++;
                end else begin
                    pending = 0;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL sb_underflow: data phase completed with no expected entry");
                    end else begin
                        e = sb.pop_front();
                        if (e.err) ok = ifc.hresp && lo_err == 1 && lo_ok == 0;
                        else       ok = !ifc.hresp && lo_err == 0 && lo_ok == e.waits &&
                                        (!e.chk || ifc.hrdata === e.data);
                        if (!ok) begin
                            fails++;
                            $display("FAIL resp addr=%h: got hresp=%0d hrdata=%h waits=%0d errlow=%0d, want err=%0d hrdata=%h waits=%0d",
                                     e.addr, ifc.hresp, ifc.hrdata, lo_ok, lo_err, e.err, e.data,
                                     e.err ? 0 : e.waits);
                        end
                    end
                end
            end else begin
                tests++;
                if (!(ifc.hreadyout === 1'b1 && ifc.hresp === 1'b0)) begin
                    fails++;
                    $display("FAIL idle_resp: got hreadyout=%0d hresp=%0d, want 1 0",
                             ifc.hreadyout, ifc.hresp);
                end
            end
            if (ifc.hsel && ifc.hready && ifc.htrans[1] && ifc.hreadyout) begin
                pending = 1; lo_ok = 0; lo_err = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Presents one address phase and holds it until the slave is ready; returns 1ns after acceptance.
    task automatic issue(input logic [1:0] tr, input logic [31:0] a, input logic w,
                         input logic [2:0] b, input logic [2:0] sz, input logic [31:0] wd);
        int k;
        bit acc;
        ifc.hsel = 1'b1; ifc.htrans = tr; ifc.haddr = a;
        ifc.hwrite = w; ifc.hburst = b; ifc.hsize = sz;
        acc = 0; k = 0;
        while (!acc && k < 64) begin
            @(negedge hclk);
            k++;
            if (ifc.hreadyout) acc = 1;
        end
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout addr=%h: hreadyout stuck at 0, want 1 within 64 cycles", a);
        end else if (tr[1]) begin
            model_accept(tr, a, w, b, sz, wd);
        end
        @(posedge hclk); #1;
        ifc.hwdata = wd;
        ifc.htrans = T_IDLE;
    endtask

    task automatic rd(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b);
        issue(tr, a, 1'b0, b, 3'b010, 32'd0);
    endtask

    task automatic preload(input int i, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 8'(i); ld_data = d;
        mmem[i] = d;
        @(posedge hclk); #1;
        ld_en = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((pending || sb.size() != 0) && k < 64) begin
            @(posedge hclk); #1;
            k++;
        end
        if (pending || sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb.size());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge hclk); #1; end
    endtask

    initial begin
        ifc.hsel = 1'b0; ifc.htrans = T_IDLE; ifc.haddr = 32'd0; ifc.hwrite = 1'b0;
        ifc.hsize = 3'b010; ifc.hburst = B_SINGLE; ifc.hwdata = 32'd0;
        ld_en = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;

        repeat (3) @(posedge hclk);
        #1;
        chk("rst_hreadyout", 32'(ifc.hreadyout), 32'd1);
        chk("rst_hresp",     32'(ifc.hresp),     32'd0);
        chk("rst_hrdata",    ifc.hrdata,         32'd0);
        hrstn = 1'b1;

        for (int i = 0; i < MW; i++)
            preload(i, (i < 4) ? (32'hA0 + 32'(i)) : $urandom);

        // WRAP4 line fill starting mid-line
        rd(T_NSEQ, 32'h8, B_WRAP4);
        rd(T_SEQ,  32'hC, B_WRAP4);
        rd(T_SEQ,  32'h0, B_WRAP4);
        rd(T_SEQ,  32'h4, B_WRAP4);
        rd(T_SEQ,  32'h8, B_WRAP4);
        drain();

        // Just past the top of memory, then a normal read
        rd(T_NSEQ, 32'(4 * MW), B_SINGLE);
        rd(T_NSEQ, 32'h0, B_SINGLE);
        drain();

        // Wrong SEQ address ends the burst; a further SEQ has no burst to belong to
        rd(T_NSEQ, 32'h4, B_WRAP4);
        rd(T_SEQ,  32'hC, B_WRAP4);
        rd(T_SEQ,  32'h8, B_WRAP4);
        drain();

        // INCR4 with a BUSY between beats 2 and 3
        rd(T_NSEQ, 32'h0, B_INCR4);
        rd(T_SEQ,  32'h4, B_INCR4);
        rd(T_BUSY, 32'h8, B_INCR4);
        rd(T_SEQ,  32'h8, B_INCR4);
        rd(T_SEQ,  32'hC, B_INCR4);
        drain();

        // Misaligned address and non-word size
        rd(T_NSEQ, 32'h2, B_SINGLE);
        issue(T_NSEQ, 32'h0, 1'b0, B_SINGLE, 3'b001, 32'd0);
        rd(T_NSEQ, 32'h4, B_SINGLE);
        drain();

        // Word write then readback
        issue(T_NSEQ, 32'h10, 1'b1, B_SINGLE, 3'b010, 32'hDEADBEEF);
        rd(T_NSEQ, 32'h10, B_SINGLE);
        drain();

        // Asynchronous reset during the wait states of a NONSEQ
        rd(T_NSEQ, 32'h20, B_SINGLE);
        #2;
        hrstn = 1'b0;
        #1;
        chk("async_rst_hreadyout", 32'(ifc.hreadyout), 32'd1);
        chk("async_rst_hresp",     32'(ifc.hresp),     32'd0);
        chk("async_rst_hrdata",    ifc.hrdata,         32'd0);
        sb.delete();
        pending = 0;
        m_act = 0;
        @(posedge hclk);
        @(negedge hclk);
        hrstn = 1'b1;
        @(posedge hclk); #1;
        rd(T_NSEQ, 32'h20, B_SINGLE);
        drain();

        // Randomized bursts with occasional protocol violations, BUSY beats and preloads
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  b;
            logic [31:0] a;
            logic        w;
            logic [2:0]  sz;
            int          r;
            int          nseq;
            b  = 3'($urandom_range(0, 3));
            a  = {22'd0, 8'($urandom_range(0, MW - 1)), 2'b00};
            w  = 1'b0;
            sz = 3'b010;
            r  = $urandom_range(0, 15);
            if (r == 0)      a = a + 32'd1;
            else if (r == 1) a = a + 32'(4 * MW);
            else if (r == 2) sz = 3'b001;
            else if (r == 3) w = 1'b1;
            if (b == B_SINGLE)    nseq = ($urandom_range(0, 7) == 0) ? 1 : 0;
            else if (b == B_INCR) nseq = $urandom_range(0, 5);
            else                  nseq = ($urandom_range(0, 5) == 0) ? 4 : 3;
            issue(T_NSEQ, a, w, b, sz, $urandom);
            for (int s = 0; s < nseq; s++) begin
                if (b == B_WRAP4) a = (a & ~32'hF) | ((a + 32'd4) & 32'hC);
                else              a = a + 32'd4;
                if ($urandom_range(0, 11) == 0) a = a + 32'd8;
                if ($urandom_range(0, 4) == 0) issue(T_BUSY, a, w, b, sz, 32'd0);
                issue(T_SEQ, a, w, b, sz, $urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                drain();
                preload($urandom_range(0, MW - 1), $urandom);
            end
            idle($urandom_range(0, 2));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ahb_imem_slave.md
Name: ahb_imem_slave

Overview:
- AHB-lite slave instruction memory; downstream responder for the I-cache's line-fill master port.
- Serves single and WRAP4/INCR4 read bursts with programmable wait states.
- Checks bursts for protocol errors and answers with the two-cycle ERROR response.
- Side-band preload port lets the bench or boot logic fill memory while the bus is idle.

Parameters:
- MEM_WORDS, 4096, memory depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000, byte base address of the memory window.
- NSEQ_WAIT, 2, wait states inserted on a NONSEQ beat (0..15).
- SEQ_WAIT, 0, wait states inserted on each SEQ beat (0..15).

Ports:
- hclk  in  1  bus clock
- hrstn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  32  byte address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write
- hsize  in  3  transfer size; only 3'b010 (word) legal
- hburst  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3
- hready  in  1  bus-level ready (address-phase qualifier)
- hwdata  in  32  write data
- hrdata  out  32  read data
- hreadyout  out  1  slave ready
- hresp  out  1  0=OKAY, 1=ERROR
- ld_en  in  1  preload strobe
- ld_addr  in  $clog2(MEM_WORDS)  preload word index
- ld_data  in  32  preload word

Behaviour:
- Clock and reset: one clock, hclk; reset hrstn is asynchronous, active-low.
- Reset values: hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0, burst tracker cleared. Memory contents are not reset.
- Address phase accepted when hsel & hready & htrans[1]. The data phase follows in the next cycle.
- Accepted control (addr, write, size, burst, trans) is registered. An address phase presented while hreadyout=0 is ignored.
- Legality checks (any failure means ERROR, memory untouched):
  - hsize==3'b010 and haddr[1:0]==0;
  - BASE_ADDR <= haddr < BASE_ADDR+4*MEM_WORDS;
  - hwrite==0 (see optional feature);
  - for SEQ, haddr equals the expected address: WRAP4 is {prev[31:4], prev[3:2]+1, 2'b00}, INCR4/INCR is prev+4;
  - SEQ with no burst in progress.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on accepted legal transfer with wait count 0, go to DATA; with wait count >0, load counter and go to WAIT. On illegal transfer, go to ERR1.
  - WAIT: hreadyout=0, hresp=0; decrement counter; go to DATA when counter reaches 1.
  - DATA: hreadyout=1, hresp=0, hrdata=mem[(addr-BASE_ADDR)>>2]. Memory is read when entering DATA, so hrdata is valid for exactly this cycle. A new address phase accepted in DATA is pipelined: same transition rules as IDLE, otherwise return to IDLE.
  - ERR1: hreadyout=0, hresp=1. Go to ERR2.
  - ERR2: hreadyout=1, hresp=1. Address phases accepted here are processed as in IDLE.
- Wait counts: NONSEQ uses NSEQ_WAIT, SEQ uses SEQ_WAIT.
- BUSY and IDLE trans, or hsel=0: zero-wait OKAY, no access. BUSY does not break the burst tracker.
- Burst tracker:
  - NONSEQ starts a burst with beat count 1. Each SEQ increments it.
  - WRAP4/INCR4 end after beat 4; a 5th SEQ is an error.
  - ERROR terminates the burst and clears the tracker.
- Preload: ld_en writes mem[ld_addr]<=ld_data on the clock edge. If it coincides with a read of the same word in the same cycle, the read returns the old data.
- Reset mid-burst: outputs return to reset values immediately (asynchronous); the tracker clears.
- Latency: hrdata is valid (hreadyout=1) NONSEQ_WAIT+1 cycles after a NONSEQ address phase and SEQ_WAIT+1 cycles after a SEQ address phase.
  - A WRAP4 fill takes 4 + NSEQ_WAIT + 3*SEQ_WAIT data cycles.

Optional Feature:
- Macro: AHB_IMEM_WRITE_EN.
- Defined: legal word writes are accepted. The data phase stores hwdata to the registered address in DATA, with the same wait-state timing and hresp=OKAY. A preload to the same word in the same cycle loses to the bus write.
- Undefined: any hwrite=1 transfer gets the two-cycle ERROR response and memory is unchanged.

Test Plan:
- Preload mem[0..3]=32'hA0..A3, NSEQ_WAIT=2, SEQ_WAIT=0. WRAP4 NONSEQ at 0x8 then SEQ 0xC, 0x0, 0x4 -> hreadyout low for 2 cycles, then hrdata A2, A3, A0, A1 on consecutive cycles, hresp=0 throughout.
- SINGLE read at BASE_ADDR+4*MEM_WORDS -> hreadyout 0/1 with hresp 1/1 over two cycles; next NONSEQ to 0x0 returns 32'hA0 OKAY.
- WRAP4 from 0x4, second beat SEQ with haddr=0xC instead of 0x8 -> ERROR on that beat; burst tracker cleared.
- INCR4 with BUSY inserted between beats 2 and 3 -> BUSY gets a zero-wait OKAY, beat 3 address 0x8 is still accepted, data correct.
- hwrite=1 word write of 32'hDEADBEEF to 0x10 -> without AHB_IMEM_WRITE_EN: ERROR, and a readback of 0x10 is unchanged. With the macro: OKAY, and the readback returns DEADBEEF.
- hrstn asserted during the WAIT state of a NONSEQ -> hreadyout=1, hresp=0, hrdata=0 immediately. After release, a fresh NONSEQ completes normally.
